input_debouncer: RTL and testbench

- Conditions a raw, asynchronous, bouncy input (pushbutton or switch) into a clean, synchronous level.
- Sits directly upstream of edge_detector / edge_detector_moore. Its `out` drives their `in`, so each physical press yields exactly one positive_edge and one negative_edge.
- Two-stage-or-more synchronizer followed by a counter-qualified four-state FSM.

---
 rtl/input_debouncer_if.sv | 24 ++
 rtl/input_debouncer.sv | 129 ++++++++++++
 tb/tb_input_debouncer.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/input_debouncer_if.sv
`default_nettype none
// ============================================================================
// Module      : input_debouncer_if
// Description : Raw input and conditioned outputs of the input debouncer.
// Revision    : 1.0 - initial release
// ============================================================================
interface input_debouncer_if;
    logic in;
    logic out;
    logic busy;

    modport master (
        output in,
        input  out,
        input  busy
    );

    modport slave (
        input  in,
        output out,
        output busy
    );
endinterface
`default_nettype wire

// File: rtl/input_debouncer.sv
`default_nettype none
// ============================================================================
// Module      : input_debouncer
// Description : Synchronizes a bouncy asynchronous input and qualifies each
//               level change over BOUNCE_TICKS consecutive samples.
// Revision    : 1.0 - initial release
// ============================================================================
module input_debouncer #(
    parameter int   SYNC_STAGES  = 2,
    parameter int   BOUNCE_TICKS = 4,
    parameter logic RESET_LEVEL  = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    input_debouncer_if.slave   bus
);

    localparam int c_cnt_w = $clog2(BOUNCE_TICKS + 1);
    localparam logic [c_cnt_w-1:0] c_one  = c_cnt_w'(1);
    localparam logic [c_cnt_w-1:0] c_zero = '0;
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(BOUNCE_TICKS - 1);

    typedef enum logic [1:0] {
        STABLE_LOW  = 2'b00,
        MAYBE_HIGH  = 2'b01,
        STABLE_HIGH = 2'b10,
        MAYBE_LOW   = 2'b11
    } state_t;

    localparam state_t c_reset_state = RESET_LEVEL ? STABLE_HIGH : STABLE_LOW;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_s;
    state_t                 r_state;
    state_t                 w_state_next;
    logic [c_cnt_w-1:0]     r_count;
    logic [c_cnt_w-1:0]     w_count_next;
    logic                   r_out;
    logic                   w_out_next;
    logic                   r_busy;
    logic                   w_busy_next;

    // Only the last synchronizer stage is allowed to reach the FSM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= {SYNC_STAGES{RESET_LEVEL}};
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], bus.in};
        end
    end

    assign w_s = r_sync[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_reset_state;
            r_count <= c_zero;
            r_out   <= RESET_LEVEL;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_count <= w_count_next;
            r_out   <= w_out_next;
            r_busy  <= w_busy_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_count_next = r_count;
        w_out_next   = r_out;
        w_busy_next  = r_busy;
        case (r_state)
            STABLE_LOW: begin
                if (w_s) begin
                    w_state_next = MAYBE_HIGH;
                    w_count_next = c_one;
                    w_busy_next  = 1'b1;
                end
            end
            MAYBE_HIGH: begin
                if (!w_s) begin
                    w_state_next = STABLE_LOW;
                    w_count_next = c_zero;
                    w_busy_next  = 1'b0;
                end else if (r_count == c_last) begin
                    w_state_next = STABLE_HIGH;
                    w_count_next = c_zero;
                    w_out_next   = 1'b1;
                    w_busy_next  = 1'b0;
                end else begin
                    w_count_next = r_count + c_one;
                end
            end
            STABLE_HIGH: begin
                if (!w_s) begin
                    w_state_next = MAYBE_LOW;
                    w_count_next = c_one;
                    w_busy_next  = 1'b1;
                end
            end
            MAYBE_LOW: begin
                if (w_s) begin
                    w_state_next = STABLE_HIGH;
                    w_count_next = c_zero;
                    w_busy_next  = 1'b0;
                end else if (r_count == c_last) begin
                    w_state_next = STABLE_LOW;
                    w_count_next = c_zero;
                    w_out_next   = 1'b0;
                    w_busy_next  = 1'b0;
                end else begin
                    w_count_next = r_count + c_one;
                end
            end
            default: begin
                w_state_next = STABLE_LOW;
                w_count_next = c_zero;
                w_out_next   = 1'b0;
                w_busy_next  = 1'b0;
            end
        endcase
    end

    assign bus.out  = r_out;
    assign bus.busy = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_input_debouncer.sv
`default_nettype none
// ============================================================================
// Module      : tb_input_debouncer
// Description : Directed self-checking bench for input_debouncer (defaults).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_input_debouncer;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;
    int   rise_cnt;
    int   gap;
    logic prev_out;

    input_debouncer_if dif ();

    input_debouncer #(
        .SYNC_STAGES  (2),
        .BOUNCE_TICKS (4),
        .RESET_LEVEL  (1'b0)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (dif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic obs, input logic exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Edge k=1 is the first rising edge sampling the new level; out moves at k=6
    // and busy covers the three edges just before it.
    task automatic qualify(input logic lvl, input string tag);
        for (int k = 1; k <= 6; k++) begin
            tick();
            check({tag, "_out"}, dif.out, (k == 6) ? lvl : ~lvl);
            if (k >= 3) check({tag, "_busy"}, dif.busy, (k < 6));
        end
    endtask

    task automatic hold(input int n, input string tag);
        for (int k = 0; k < n; k++) begin
            tick();
            check(tag, dif.out, dif.in);
        end
    endtask

    // Edge bookkeeping of out: rising-edge count and spacing between toggles.
    always @(negedge clk) begin
        gap = gap + 1;
        if (dif.out !== prev_out) begin
            if (dif.out === 1'b1) rise_cnt++;
            check("toggle_gap", (gap >= 4), 1'b1);
            gap = 0;
        end
        prev_out = dif.out;
    end

    initial begin
        int   rises_before;
        logic busy_seen;
        int   stable;
        int   d;

        n_checks = 0;
        n_errors = 0;
        rise_cnt = 0;
        gap      = 1000;
        prev_out = 1'b0;
        rst      = 1'b1;
        dif.in   = 1'b1;

        // Reset held with in = 1
        for (int k = 0; k < 3; k++) begin
            tick();
            check("rst_out", dif.out, 1'b0);
            check("rst_busy", dif.busy, 1'b0);
        end
        @(negedge clk);
        rst = 1'b0;
        qualify(1'b1, "post_rst");
        hold(14, "post_rst_hold");

        // Clean release / press / release
        @(negedge clk);
        dif.in = 1'b0;
        qualify(1'b0, "rel1");
        hold(14, "rel1_hold");
        @(negedge clk);
        dif.in = 1'b1;
        qualify(1'b1, "press");
        hold(14, "press_hold");
        @(negedge clk);
        dif.in = 1'b0;
        qualify(1'b0, "rel2");
        hold(14, "rel2_hold");

        // Bounce 1,0,1,0 then final 1
        rises_before = rise_cnt;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            dif.in = (i % 2 == 0);
            tick();
            check("bounce_out", dif.out, 1'b0);
        end
        @(negedge clk);
        dif.in = 1'b1;
        qualify(1'b1, "bounce");
        hold(10, "bounce_hold");
        check("bounce_one_rise", (rise_cnt - rises_before == 1), 1'b1);
        @(negedge clk);
        dif.in = 1'b0;
        qualify(1'b0, "bounce_rel");
        hold(10, "bounce_rel_hold");

        // Three-cycle glitch must be filtered
        busy_seen = 1'b0;
        @(negedge clk);
        dif.in = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            busy_seen = busy_seen | dif.busy;
            check("glitch_out", dif.out, 1'b0);
        end
        @(negedge clk);
        dif.in = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            busy_seen = busy_seen | dif.busy;
            check("glitch_out", dif.out, 1'b0);
        end
        check("glitch_busy_seen", busy_seen, 1'b1);
        check("glitch_busy_end", dif.busy, 1'b0);

        // Async reset while MAYBE_HIGH with count = 2
        @(negedge clk);
        dif.in = 1'b1;
        for (int k = 0; k < 4; k++) tick();
        check("mid_busy_before", dif.busy, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_busy", dif.busy, 1'b0);
        check("mid_rst_out", dif.out, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        qualify(1'b1, "mid_restart");
        hold(6, "mid_hold");

        // Random stress
        stable = 0;
        for (int t = 0; t < 10; t++) begin
            d = $urandom_range(127, 0) + 1;
            for (int j = 0; j < d; j++) begin
                tick();
                stable++;
                if (stable >= 6) check("stress_out", dif.out, dif.in);
            end
            @(negedge clk);
            dif.in = ~dif.in;
            stable = 0;
        end
        for (int j = 0; j < 10; j++) begin
            tick();
            stable++;
            if (stable >= 6) check("stress_final", dif.out, dif.in);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
